// File: rtl/bola_inimiga_pkg.sv
// Shared definitions for the enemy launcher block: screen geometry,
// FSM state encoding, score ceiling and small arithmetic helpers.
package bola_inimiga_pkg;

    // Screen geometry of the renderer this block feeds.
    localparam int LARGURA_TELA = 640;
    localparam int ALTURA_TELA  = 480;

    // Ceiling of the two-digit HEX score display.
    localparam int PLACAR_MAX = 99;

    // Width of coordinate arithmetic: one bit wider than the 10-bit ports.
    localparam int COORD_W = 11;

    // Enemy-shot controller states.
    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        DISPARO = 2'd1,
        PERDEU  = 2'd2
    } estado_t;

    // Zero-extend a 10-bit screen coordinate to the arithmetic width.
    function automatic logic [COORD_W-1:0] estende(input logic [9:0] v);
        return {1'b0, v};
    endfunction

    // Increment the hit counter, holding at the display ceiling.
    function automatic logic [6:0] placar_inc(input logic [6:0] v);
        if (v >= 7'(PLACAR_MAX)) begin
            return 7'(PLACAR_MAX);
        end
        return v + 7'd1;
    endfunction

endpackage

// File: rtl/bola_inimiga_colisao_caixa.sv
// Combinational overlap test between a square of half-size `meia` centred
// on (cx, cy) and an axis-aligned box [bx, bx+bw] x [by, by+bh].
// A point target is expressed as a box with bw = bh = 0, which turns the
// test into |cx-bx| <= meia and |cy-by| <= meia without any subtraction.
module colisao_caixa
    import bola_inimiga_pkg::*;
(
    input  logic               enable,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [COORD_W-1:0] meia,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] bw,
    input  logic [COORD_W-1:0] bh,
    output logic               hit
);

    // Two guard bits so the three-term sums can never wrap.
    localparam int SW = COORD_W + 2;

    logic x_ok;
    logic y_ok;

    // Interval overlap per axis, rearranged so only additions appear.
    always_comb begin
        x_ok = ((SW'(cx) + SW'(meia)) >= SW'(bx)) &&
               ((SW'(bx) + SW'(bw) + SW'(meia)) >= SW'(cx));
        y_ok = ((SW'(cy) + SW'(meia)) >= SW'(by)) &&
               ((SW'(by) + SW'(bh) + SW'(meia)) >= SW'(cy));
        hit  = enable && x_ok && y_ok;
    end

endmodule

// File: rtl/bola_inimiga.sv
// Enemy launcher and enemy-shot controller: sweeps the launcher along its
// row, fires a falling ball after a delay, detects ship hits (game over)
// and allied-ball hits on the launcher (score).
module bola_inimiga
    import bola_inimiga_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int Y_LAUNCH   = 100,
    parameter int X_MIN      = 20,
    parameter int X_MAX      = 620,
    parameter int X_STEP     = 2,
    parameter int SHOT_STEP  = 4,
    parameter int Y_LIMIT    = 479,
    parameter int RAIO       = 5,
    parameter int FIRE_DELAY = 50
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] largura_nave,
    input  logic [9:0] altura_nave,
    input  logic [9:0] x_bola_aliada,
    input  logic [9:0] y_bola_aliada,
    input  logic [9:0] raio_bola_aliada,
    output logic [9:0] x_bola_inimiga,
    output logic [9:0] y_bola_inimiga,
    output logic [9:0] raio_bola_inimiga,
    output logic [9:0] x_inimigo,
    output logic       perdeu,
    output logic [6:0] acertos,
    output logic       acerto
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (FIRE_DELAY > 1) ? $clog2(FIRE_DELAY) : 1;

    localparam logic [PW-1:0]      PRESC_FIM = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      DELAY_FIM = DW'(FIRE_DELAY - 1);
    localparam logic [COORD_W-1:0] X_MIN_W   = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_MAX_W   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] X_STEP_W  = COORD_W'(X_STEP);
    localparam logic [COORD_W-1:0] SHOT_W    = COORD_W'(SHOT_STEP);
    localparam logic [COORD_W-1:0] Y_LIMIT_W = COORD_W'(Y_LIMIT);
    localparam logic [COORD_W-1:0] RAIO_W    = COORD_W'(RAIO);
    localparam logic [9:0]         Y_LAUNCH_V = 10'(Y_LAUNCH);
    localparam logic [9:0]         X_MIN_V    = 10'(X_MIN);
    localparam logic [9:0]         RAIO_V     = 10'(RAIO);

    // Restart request: active-low reset or the game-restart button.
    logic srst;
    assign srst = !reset || reiniciarJogo;

    // ---------------------------------------------------------------
    // Game-tick prescaler
    // ---------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic          tick;

    assign tick = !pausa && (presc_reg == PRESC_FIM);

    // Free-running tick divider, frozen while paused.
    always_ff @(posedge CLOCK_50) begin
        if (srst) begin
            presc_reg <= '0;
        end else if (!pausa) begin
            if (presc_reg == PRESC_FIM) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    estado_t       state_reg, state_next;
    logic [DW-1:0] delay_reg, delay_next;
    logic [9:0]    x_inim_reg, x_inim_next;
    logic          dir_reg, dir_next;          // 1 = moving right
    logic [9:0]    x_bola_reg, x_bola_next;
    logic [9:0]    y_bola_reg, y_bola_next;
    logic [9:0]    raio_reg, raio_next;
    logic          perdeu_reg, perdeu_next;
    logic [6:0]    acertos_reg, acertos_next;
    logic          acerto_reg, acerto_next;
    logic          overlap_prev_reg, overlap_prev_next;

    // ---------------------------------------------------------------
    // Collision detectors
    // ---------------------------------------------------------------
    logic hit_nave;
    logic overlap_lancador;

    // Enemy ball square against the ship box; only meaningful mid-shot.
    colisao_caixa u_colisao_nave (
        .enable (state_reg == DISPARO),
        .cx     (estende(x_bola_reg)),
        .cy     (estende(y_bola_reg)),
        .meia   (RAIO_W),
        .bx     (estende(x_nave)),
        .by     (estende(y_nave)),
        .bw     (estende(largura_nave)),
        .bh     (estende(altura_nave)),
        .hit    (hit_nave)
    );

    // Allied ball centre as a point against the launcher grown by both radii.
    colisao_caixa u_colisao_lancador (
        .enable (raio_bola_aliada != 10'd0),
        .cx     (estende(x_inim_reg)),
        .cy     (estende(Y_LAUNCH_V)),
        .meia   (estende(raio_bola_aliada) + RAIO_W),
        .bx     (estende(x_bola_aliada)),
        .by     (estende(y_bola_aliada)),
        .bw     ('0),
        .bh     ('0),
        .hit    (overlap_lancador)
    );

    // ---------------------------------------------------------------
    // Launcher sweep: next position if this is a moving tick
    // ---------------------------------------------------------------
    logic [COORD_W-1:0] x_cur;
    logic [COORD_W-1:0] x_move;
    logic               dir_move;

    assign x_cur = estende(x_inim_reg);

    // Bounce between the sweep limits, clamping onto the limit on arrival.
    always_comb begin
        x_move   = x_cur;
        dir_move = dir_reg;
        if (dir_reg) begin
            if ((x_cur + X_STEP_W) >= X_MAX_W) begin
                x_move   = X_MAX_W;
                dir_move = 1'b0;
            end else begin
                x_move = x_cur + X_STEP_W;
            end
        end else begin
            if (x_cur <= (X_MIN_W + X_STEP_W)) begin
                x_move   = X_MIN_W;
                dir_move = 1'b1;
            end else begin
                x_move = x_cur - X_STEP_W;
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM next-state and datapath updates
    // ---------------------------------------------------------------
    logic [COORD_W-1:0] y_cur;
    assign y_cur = estende(y_bola_reg);

    // Everything advances only on a tick and never once the game is lost.
    always_comb begin
        state_next        = state_reg;
        delay_next        = delay_reg;
        x_inim_next       = x_inim_reg;
        dir_next          = dir_reg;
        x_bola_next       = x_bola_reg;
        y_bola_next       = y_bola_reg;
        raio_next         = raio_reg;
        perdeu_next       = perdeu_reg;
        acertos_next      = acertos_reg;
        acerto_next       = 1'b0;
        overlap_prev_next = overlap_prev_reg;

        if (tick && (state_reg != PERDEU)) begin
            x_inim_next = x_move[9:0];
            dir_next    = dir_move;

            // Score only on the rising edge of the sampled overlap; this
            // also runs on the tick that ends the game.
            overlap_prev_next = overlap_lancador;
            if (overlap_lancador && !overlap_prev_reg) begin
                acerto_next  = 1'b1;
                acertos_next = placar_inc(acertos_reg);
            end

            case (state_reg)
                ESPERA: begin
                    if (delay_reg == DELAY_FIM) begin
                        // Launch from where the launcher stood this tick.
                        delay_next  = '0;
                        state_next  = DISPARO;
                        x_bola_next = x_inim_reg;
                        y_bola_next = Y_LAUNCH_V;
                        raio_next   = RAIO_V;
                    end else begin
                        delay_next  = delay_reg + DW'(1);
                        x_bola_next = x_move[9:0];
                        y_bola_next = Y_LAUNCH_V;
                    end
                end
                DISPARO: begin
                    // Ship hit takes priority over leaving the screen.
                    if (hit_nave) begin
                        state_next  = PERDEU;
                        perdeu_next = 1'b1;
                    end else if ((y_cur + SHOT_W) > Y_LIMIT_W) begin
                        state_next  = ESPERA;
                        raio_next   = '0;
                        x_bola_next = x_move[9:0];
                        y_bola_next = Y_LAUNCH_V;
                    end else begin
                        y_bola_next = 10'(y_cur + SHOT_W);
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // Register bank with synchronous restart.
    always_ff @(posedge CLOCK_50) begin
        if (srst) begin
            state_reg        <= ESPERA;
            delay_reg        <= '0;
            x_inim_reg       <= X_MIN_V;
            dir_reg          <= 1'b1;
            x_bola_reg       <= X_MIN_V;
            y_bola_reg       <= Y_LAUNCH_V;
            raio_reg         <= '0;
            perdeu_reg       <= 1'b0;
            acertos_reg      <= '0;
            acerto_reg       <= 1'b0;
            overlap_prev_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            delay_reg        <= delay_next;
            x_inim_reg       <= x_inim_next;
            dir_reg          <= dir_next;
            x_bola_reg       <= x_bola_next;
            y_bola_reg       <= y_bola_next;
            raio_reg         <= raio_next;
            perdeu_reg       <= perdeu_next;
            acertos_reg      <= acertos_next;
            acerto_reg       <= acerto_next;
            overlap_prev_reg <= overlap_prev_next;
        end
    end

    assign x_bola_inimiga    = x_bola_reg;
    assign y_bola_inimiga    = y_bola_reg;
    assign raio_bola_inimiga = raio_reg;
    assign x_inimigo         = x_inim_reg;
    assign perdeu            = perdeu_reg;
    assign acertos           = acertos_reg;
    assign acerto            = acerto_reg;

endmodule

// File: tb/tb_bola_inimiga.sv
// Scoreboard bench for bola_inimiga: stimulus pushes hand-computed
// post-tick snapshots, a monitor pops them on each tick/restart response.
module tb_bola_inimiga;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic       reset = 1'b0;
    logic       pausa = 1'b0;
    logic       reiniciarJogo = 1'b0;
    logic [9:0] x_nave = 10'd500;
    logic [9:0] y_nave = 10'd400;
    logic [9:0] largura_nave = 10'd10;
    logic [9:0] altura_nave = 10'd10;
    logic [9:0] x_bola_aliada = 10'd25;
    logic [9:0] y_bola_aliada = 10'd100;
    logic [9:0] raio_bola_aliada = 10'd0;
    logic [9:0] x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga, x_inimigo;
    logic       perdeu, acerto;
    logic [6:0] acertos;

    bola_inimiga #(
        .TICK_DIV(4), .Y_LAUNCH(100), .X_MIN(20), .X_MAX(30), .X_STEP(2),
        .SHOT_STEP(4), .Y_LIMIT(120), .RAIO(5), .FIRE_DELAY(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa),
        .reiniciarJogo(reiniciarJogo),
        .x_nave(x_nave), .y_nave(y_nave),
        .largura_nave(largura_nave), .altura_nave(altura_nave),
        .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada),
        .raio_bola_aliada(raio_bola_aliada),
        .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga),
        .raio_bola_inimiga(raio_bola_inimiga), .x_inimigo(x_inimigo),
        .perdeu(perdeu), .acertos(acertos), .acerto(acerto)
    );

    typedef struct {
        bit       evt;     // 0 = post-tick, 1 = post-restart
        bit [6:0] mask;    // xi, xb, yb, rb, pd, ac, pl
        int       tag;
        int       xi, xb, yb, rb, pd, ac, pl;
    } exp_t;

    exp_t fila[$];
    int checks = 0;
    int passes = 0;

    task automatic cmp(input string nm, input int tag, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s (tag %0d): got %0d, expected %0d", nm, tag, act, req);
    endtask

    task automatic push(input bit evt, input bit [6:0] mask, input int tag,
                        input int xi, input int xb, input int yb, input int rb,
                        input int pd, input int ac, input int pl);
        exp_t e;
        e.evt = evt; e.mask = mask; e.tag = tag;
        e.xi = xi; e.xb = xb; e.yb = yb; e.rb = rb;
        e.pd = pd; e.ac = ac; e.pl = pl;
        fila.push_back(e);
    endtask

    // Reference timing of tick/restart responses (when the DUT must answer).
    logic       restart_now;
    logic [1:0] ref_cnt = 2'd0;
    logic       prev_restart = 1'b0;
    logic       post_tick = 1'b0;
    logic       post_rst = 1'b0;
    assign restart_now = !reset || reiniciarJogo;

    always @(posedge CLOCK_50) begin
        post_rst     <= restart_now && !prev_restart;
        prev_restart <= restart_now;
        post_tick    <= !restart_now && !pausa && (ref_cnt == 2'd3);
        if (restart_now) ref_cnt <= 2'd0;
        else if (!pausa) ref_cnt <= ref_cnt + 2'd1;
    end

    // Monitor: pop and compare on each response cycle, else outputs must hold.
    logic [47:0] snap_prev;
    bit          armed = 1'b0;
    wire  [47:0] snap = {x_inimigo, x_bola_inimiga, y_bola_inimiga,
                         raio_bola_inimiga, perdeu, acertos};

    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (post_tick || post_rst) begin
                if (fila.size() != 0) begin
                    e = fila.pop_front();
                    $display("txn %s %0d: x_inimigo=%0d bola=(%0d,%0d) raio=%0d perdeu=%0d acertos=%0d acerto=%0d",
                             e.evt ? "restart" : "tick", e.tag, x_inimigo, x_bola_inimiga,
                             y_bola_inimiga, raio_bola_inimiga, perdeu, acertos, acerto);
                    cmp("event_kind", e.tag, post_rst ? 1 : 0, e.evt ? 1 : 0);
                    if (e.mask[0]) cmp("x_inimigo", e.tag, int'(x_inimigo), e.xi);
                    if (e.mask[1]) cmp("x_bola_inimiga", e.tag, int'(x_bola_inimiga), e.xb);
                    if (e.mask[2]) cmp("y_bola_inimiga", e.tag, int'(y_bola_inimiga), e.yb);
                    if (e.mask[3]) cmp("raio_bola_inimiga", e.tag, int'(raio_bola_inimiga), e.rb);
                    if (e.mask[4]) cmp("perdeu", e.tag, int'(perdeu), e.pd);
                    if (e.mask[5]) cmp("acertos", e.tag, int'(acertos), e.ac);
                    if (e.mask[6]) cmp("acerto", e.tag, int'(acerto), e.pl);
                end
                armed = 1'b1;
            end else if (armed) begin
                cmp("hold_between_ticks", -1,
                    ((snap == snap_prev) && (acerto == 1'b0)) ? 1 : 0, 1);
            end
            snap_prev = snap;
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (!post_tick && n < 100);
        if (!post_tick) cmp("tick_timeout", n, 0, 1);
    endtask

    task automatic restart_pulse();
        push(1'b1, 7'h7F, 0, 20, 20, 100, 0, 0, 0, 0);
        reiniciarJogo = 1'b1;
        @(negedge CLOCK_50);
        reiniciarJogo = 1'b0;
    endtask

    // Phase A/B: sweep, missed shot, second shot hits the ship.
    int a_xi[17] = '{22,24,26,28,30,28,26,24,22,20,22,24,26,28,30,30,30};
    int a_xb[17] = '{22,24,24,24,24,24,24,24,22,20,22,22,22,22,22,22,22};
    int a_yb[17] = '{100,100,100,104,108,112,116,120,100,100,100,100,104,108,108,108,108};
    int a_rb[17] = '{0,0,5,5,5,5,5,5,0,0,0,5,5,5,5,5,5};
    int a_pd[17] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1};

    // Phase C: allied hits interleaved with shots, fifth hit with ship hit.
    int c_on[15] = '{1,1,1,0,1,0,1,0,1,0,0,0,1,0,1};
    int c_xi[15] = '{22,24,26,28,30,28,26,24,22,20,22,24,26,26,26};
    int c_xb[15] = '{22,24,24,24,24,24,24,24,22,20,22,22,22,22,22};
    int c_yb[15] = '{100,100,100,104,108,112,116,120,100,100,100,100,100,100,100};
    int c_rb[15] = '{0,0,5,5,5,5,5,5,0,0,0,5,5,5,5};
    int c_pd[15] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,1,1};
    int c_ac[15] = '{1,1,1,1,2,2,3,3,4,4,4,4,5,5,5};
    int c_pl[15] = '{1,0,0,0,1,0,1,0,1,0,0,0,1,0,0};

    initial begin
        // Reset held from time zero, released on a falling edge.
        push(1'b1, 7'h7F, 0, 20, 20, 100, 0, 0, 0, 0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            push(1'b0, 7'h7F, 100 + i + 1, a_xi[i], a_xb[i], a_yb[i], a_rb[i], a_pd[i], 0, 0);
            if (i == 12) begin
                x_nave = 10'd20; y_nave = 10'd110;
            end
            if (i == 15) begin
                raio_bola_aliada = 10'd3;
                for (int p = 0; p < 2; p++) begin
                    pausa = 1'b1;
                    repeat (2) @(negedge CLOCK_50);
                    pausa = 1'b0;
                    @(negedge CLOCK_50);
                end
            end
            wait_tick();
        end

        restart_pulse();
        x_nave = 10'd500; y_nave = 10'd400;

        for (int i = 0; i < 15; i++) begin
            raio_bola_aliada = (c_on[i] != 0) ? 10'd3 : 10'd0;
            if (i == 12) begin
                x_nave = 10'd0; y_nave = 10'd100; largura_nave = 10'd1000;
            end
            push(1'b0, 7'h7F, 200 + i + 1, c_xi[i], c_xb[i], c_yb[i], c_rb[i],
                 c_pd[i], c_ac[i], c_pl[i]);
            wait_tick();
        end

        restart_pulse();
        x_nave = 10'd500; y_nave = 10'd400; largura_nave = 10'd10;

        // Phase D: a hit every other tick, count must saturate at 99.
        for (int k = 1; k <= 204; k++) begin
            int n;
            raio_bola_aliada = (k % 2 == 1) ? 10'd3 : 10'd0;
            n = (k + 1) / 2;
            if (n > 99) n = 99;
            push(1'b0, 7'b1110000, 1000 + k, 0, 0, 0, 0, 0, n, k % 2);
            wait_tick();
        end

        repeat (6) @(negedge CLOCK_50);
        cmp("scoreboard_drained", 0, fila.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

endmodule
